// File: rtl/prefetch_arbiter_if.sv
// Bundle of the prefetcher, D-cache miss and memory port signals seen by
// the prefetch arbiter. The slave modport is the arbiter's view, the master
// modport is the surrounding environment's view.
interface prefetch_arbiter_if #(
    parameter int unsigned LINE_W = 256
);
    // Prefetcher side
    logic              pref_read;
    logic [31:0]       pref_addr;
    logic              pref_resp;
    // D-cache miss path
    logic              dc_read;
    logic              dc_write;
    logic [31:0]       dc_addr;
    logic [LINE_W-1:0] dc_wdata;
    logic [LINE_W-1:0] dc_rdata;
    logic              dc_resp;
    // Memory port
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    modport slave (
        input  pref_read, pref_addr,
        input  dc_read, dc_write, dc_addr, dc_wdata,
        input  mem_rdata, mem_resp,
        output pref_resp,
        output dc_rdata, dc_resp,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output pref_read, pref_addr,
        output dc_read, dc_write, dc_addr, dc_wdata,
        output mem_rdata, mem_resp,
        input  pref_resp,
        input  dc_rdata, dc_resp,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prefetch_arbiter.sv
// Arbitrates demand misses/writebacks against prefetches onto a single
// cacheline memory port, keeping prefetched lines in a small fully
// associative buffer that serves later demand reads without memory traffic.
module prefetch_arbiter #(
    parameter int unsigned LINE_W     = 256,
    parameter int unsigned s_offset   = 5,
    parameter int unsigned PB_ENTRIES = 4
) (
    input logic               clk,
    input logic               rst,
    prefetch_arbiter_if.slave bus_if
);
    localparam int unsigned TAG_W = 32 - s_offset;
    localparam int unsigned PTR_W = $clog2(PB_ENTRIES);

    typedef enum logic [2:0] {
        IDLE,
        HIT,
        DEM_RD,
        DEM_WR,
        PREF_RD,
        PREF_DROP,
        DONE
    } state_t;

    state_t                  state_q;
    logic [TAG_W-1:0]        tag_q  [PB_ENTRIES];
    logic [LINE_W-1:0]       data_q [PB_ENTRIES];
    logic [PB_ENTRIES-1:0]   valid_q;
    logic [PTR_W-1:0]        ptr_q;
    logic [TAG_W-1:0]        line_q;
    logic [LINE_W-1:0]       hit_data_q;
    logic                    mem_read_q;
    logic                    mem_write_q;

    logic [TAG_W-1:0]        dc_tag;
    logic [TAG_W-1:0]        pref_tag;
    logic [PB_ENTRIES-1:0]   dc_hit_vec;
    logic [PB_ENTRIES-1:0]   pref_hit_vec;
    logic [LINE_W-1:0]       dc_hit_data;
    logic                    fill_en;

    assign fill_en = (state_q == PREF_RD) && bus_if.mem_resp;

    // Buffer lookup for both requesters; tags are unique so OR-merging
    // the matching entries yields the single hit line.
    always_comb begin
        dc_tag       = bus_if.dc_addr[31:s_offset];
        pref_tag     = bus_if.pref_addr[31:s_offset];
        dc_hit_vec   = '0;
        pref_hit_vec = '0;
        dc_hit_data  = '0;
        for (int unsigned i = 0; i < PB_ENTRIES; i++) begin
            if (valid_q[i] && (tag_q[i] == dc_tag)) begin
                dc_hit_vec[i] = 1'b1;
                dc_hit_data   = dc_hit_data | data_q[i];
            end
            if (valid_q[i] && (tag_q[i] == pref_tag)) begin
                pref_hit_vec[i] = 1'b1;
            end
        end
    end

    // Line storage for the buffer; validity lives in the FSM block.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[ptr_q]  <= line_q;
            data_q[ptr_q] <= bus_if.mem_rdata;
        end
    end

    // Arbitration FSM with registered memory strobes and buffer bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            ptr_q       <= '0;
            line_q      <= '0;
            hit_data_q  <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus_if.dc_write) begin
                        line_q      <= dc_tag;
                        valid_q     <= valid_q & ~dc_hit_vec;
                        mem_write_q <= 1'b1;
                        state_q     <= DEM_WR;
                    end else if (bus_if.dc_read) begin
                        line_q <= dc_tag;
                        if (|dc_hit_vec) begin
                            hit_data_q <= dc_hit_data;
                            state_q    <= HIT;
                        end else begin
                            mem_read_q <= 1'b1;
                            state_q    <= DEM_RD;
                        end
                    end else if (bus_if.pref_read) begin
                        line_q <= pref_tag;
                        if (|pref_hit_vec) begin
                            state_q <= PREF_DROP;
                        end else begin
                            mem_read_q <= 1'b1;
                            state_q    <= PREF_RD;
                        end
                    end
                end
                HIT: state_q <= DONE;
                DEM_RD: begin
                    if (bus_if.mem_resp) begin
                        mem_read_q <= 1'b0;
                        state_q    <= DONE;
                    end
                end
                DEM_WR: begin
                    if (bus_if.mem_resp) begin
                        mem_write_q <= 1'b0;
                        state_q     <= DONE;
                    end
                end
                PREF_RD: begin
                    if (bus_if.mem_resp) begin
                        valid_q[ptr_q] <= 1'b1;
                        ptr_q          <= ptr_q + 1'b1;
                        mem_read_q     <= 1'b0;
                        state_q        <= DONE;
                    end
                end
                PREF_DROP: state_q <= DONE;
                DONE:      state_q <= IDLE;
                default:   state_q <= IDLE;
            endcase
        end
    end

    // Output decode; completion pulses in memory states pass mem_resp through.
    always_comb begin
        bus_if.mem_read  = mem_read_q;
        bus_if.mem_write = mem_write_q;
        bus_if.mem_addr  = (mem_read_q || mem_write_q) ? {line_q, {s_offset{1'b0}}} : '0;
        bus_if.mem_wdata = '0;
        bus_if.dc_resp   = 1'b0;
        bus_if.dc_rdata  = '0;
        bus_if.pref_resp = 1'b0;
        unique case (state_q)
            HIT: begin
                bus_if.dc_resp  = 1'b1;
                bus_if.dc_rdata = hit_data_q;
            end
            DEM_RD: begin
                bus_if.dc_resp  = bus_if.mem_resp;
                bus_if.dc_rdata = bus_if.mem_rdata;
            end
            DEM_WR: begin
                bus_if.dc_resp   = bus_if.mem_resp;
                bus_if.mem_wdata = bus_if.dc_wdata;
            end
            PREF_RD:   bus_if.pref_resp = bus_if.mem_resp;
            PREF_DROP: bus_if.pref_resp = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_prefetch_arbiter.sv
// Self-checking bench for prefetch_arbiter: directed scenarios plus a
// randomized run, all compared against a transaction-level buffer model.
module tb_prefetch_arbiter;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned S_OFF  = 5;
    localparam int unsigned PB     = 4;
    localparam logic [31:0] OFS_MASK = (32'd1 << S_OFF) - 32'd1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prefetch_arbiter_if #(.LINE_W(LINE_W)) bus ();

    prefetch_arbiter #(
        .LINE_W(LINE_W),
        .s_offset(S_OFF),
        .PB_ENTRIES(PB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus_if(bus)
    );

    int checks   = 0;
    int failures = 0;

    // Backing memory: written lines override a per-address pattern.
    logic [LINE_W-1:0] mem_store [bit [31:0]];

    function automatic logic [LINE_W-1:0] mem_val(input logic [31:0] line);
        if (mem_store.exists(line)) return mem_store[line];
        return {(LINE_W/32){line ^ 32'hC3C3_0F0F}};
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & ~OFS_MASK;
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        for (int i = 0; i < LINE_W/32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Prefetch buffer model: tag/data per slot plus round-robin pointer.
    logic [31:0]       m_tag   [PB];
    bit                m_valid [PB];
    logic [LINE_W-1:0] m_data  [PB];
    int                m_ptr;

    function automatic int m_find(input logic [31:0] line);
        for (int i = 0; i < PB; i++)
            if (m_valid[i] && m_tag[i] == line) return i;
        return -1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < PB; i++) m_valid[i] = 1'b0;
        m_ptr = 0;
    endtask

    task automatic m_fill(input logic [31:0] line);
        m_tag[m_ptr]   = line;
        m_data[m_ptr]  = mem_val(line);
        m_valid[m_ptr] = 1'b1;
        m_ptr          = (m_ptr + 1) % PB;
    endtask

    task automatic m_inval(input logic [31:0] line);
        int k;
        k = m_find(line);
        if (k >= 0) m_valid[k] = 1'b0;
    endtask

    // Memory responder: random 0-3 cycle latency, one-cycle mem_resp.
    bit hold_mem = 1'b0;
    int resp_cnt;
    initial begin
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        resp_cnt      = 0;
        forever begin
            @(negedge clk);
            if (bus.mem_resp) begin
                bus.mem_resp  = 1'b0;
                bus.mem_rdata = '0;
            end else if ((bus.mem_read || bus.mem_write) && !hold_mem && !rst) begin
                if (resp_cnt == 0) begin
                    bus.mem_resp = 1'b1;
                    if (bus.mem_read) bus.mem_rdata = mem_val(bus.mem_addr);
                    resp_cnt = $urandom_range(0, 3);
                end else begin
                    resp_cnt--;
                end
            end
        end
    end

    // Observations collected by txn (no judgement made there).
    int                o_dc_lat, o_pref_lat, o_dc_cnt, o_pref_cnt;
    int                o_rd_cyc, o_wr_cyc, o_nacc, o_acc_cyc;
    logic [31:0]       o_addr [2];
    logic [LINE_W-1:0] o_dc_data, o_wdata;
    bit                o_both, o_unstable, o_timeout, o_leak;

    // Drive one request set, hold strobes until their completion pulse,
    // answer memory, and record what the DUT did cycle by cycle.
    task automatic txn(input bit dr, input bit dw, input bit pr,
                       input logic [31:0] da, input logic [31:0] pa,
                       input logic [LINE_W-1:0] wd);
        bit dc_pend, pf_pend, prev_strobe, strobe;
        logic [31:0] prev_addr;
        int idle;
        o_dc_lat = -1; o_pref_lat = -1; o_dc_cnt = 0; o_pref_cnt = 0;
        o_rd_cyc = 0; o_wr_cyc = 0; o_nacc = 0; o_acc_cyc = -1;
        o_addr[0] = '0; o_addr[1] = '0; o_dc_data = '0; o_wdata = '0;
        o_both = 0; o_unstable = 0; o_timeout = 0; o_leak = 0;
        @(negedge clk);
        bus.dc_read = dr; bus.dc_write = dw; bus.dc_addr = da; bus.dc_wdata = wd;
        bus.pref_read = pr; bus.pref_addr = pa;
        dc_pend = dr | dw; pf_pend = pr; idle = 0; prev_strobe = 0; prev_addr = '0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk); #2;
            strobe = bus.mem_read | bus.mem_write;
            if (bus.mem_read && bus.mem_write) o_both = 1;
            if (strobe) begin
                if (!prev_strobe) begin
                    if (o_nacc < 2) o_addr[o_nacc] = bus.mem_addr;
                    if (o_nacc == 0) o_acc_cyc = cyc;
                    o_nacc++;
                end else if (bus.mem_addr !== prev_addr) o_unstable = 1;
                prev_addr = bus.mem_addr;
            end
            if (bus.mem_read) o_rd_cyc++;
            if (bus.mem_write) begin o_wr_cyc++; o_wdata = bus.mem_wdata; end
            if (!bus.dc_resp && bus.dc_rdata !== '0) o_leak = 1;
            if (bus.dc_resp) begin
                o_dc_cnt++;
                if (o_dc_cnt == 1) begin o_dc_lat = cyc; o_dc_data = bus.dc_rdata; end
                bus.dc_read = 0; bus.dc_write = 0; dc_pend = 0;
            end
            if (bus.pref_resp) begin
                o_pref_cnt++;
                if (o_pref_cnt == 1) o_pref_lat = cyc;
                bus.pref_read = 0; pf_pend = 0;
            end
            prev_strobe = strobe;
            if (!dc_pend && !pf_pend) begin
                idle++;
                if (idle == 3) break;
            end
        end
        if (dc_pend || pf_pend) o_timeout = 1;
        bus.dc_read = 0; bus.dc_write = 0; bus.pref_read = 0;
    endtask

    task automatic test_reset();
        bus.dc_read = 0; bus.dc_write = 0; bus.pref_read = 0;
        bus.dc_addr = '0; bus.pref_addr = '0; bus.dc_wdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if ({bus.mem_read, bus.mem_write, bus.dc_resp, bus.pref_resp} !== 4'b0) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=0000",
                     {bus.mem_read, bus.mem_write, bus.dc_resp, bus.pref_resp});
        end
        checks++;
        if (bus.mem_addr !== 32'h0 || bus.dc_rdata !== '0 || bus.mem_wdata !== '0) begin
            failures++;
            $display("FAIL reset_buses mem_addr=%h dc_rdata=%h mem_wdata=%h exp=0",
                     bus.mem_addr, bus.dc_rdata, bus.mem_wdata);
        end
        rst = 1'b0;
        m_reset();
    endtask

    task automatic test_pref_fill();
        txn(0, 0, 1, '0, 32'h1000_0044, '0);
        checks++;
        if (o_timeout || o_pref_cnt !== 1 || o_nacc !== 1) begin
            failures++;
            $display("FAIL pref_fill_resp timeout=%0d pref_cnt=%0d nacc=%0d exp=0/1/1",
                     o_timeout, o_pref_cnt, o_nacc);
        end
        checks++;
        if (o_addr[0] !== 32'h1000_0040 || o_acc_cyc !== 1) begin
            failures++;
            $display("FAIL pref_fill_addr got=%h@%0d exp=10000040@1", o_addr[0], o_acc_cyc);
        end
        m_fill(32'h1000_0040);
    endtask

    task automatic test_hit_latency();
        txn(1, 0, 0, 32'h1000_0050, '0, '0);
        checks++;
        if (o_nacc !== 0 || o_dc_lat !== 1 || o_dc_cnt !== 1) begin
            failures++;
            $display("FAIL hit_latency nacc=%0d lat=%0d cnt=%0d exp=0/1/1",
                     o_nacc, o_dc_lat, o_dc_cnt);
        end
        checks++;
        if (o_dc_data !== mem_val(32'h1000_0040)) begin
            failures++;
            $display("FAIL hit_data got=%h exp=%h", o_dc_data, mem_val(32'h1000_0040));
        end
    endtask

    task automatic test_demand_priority();
        txn(1, 0, 1, 32'h2000_0000, 32'h3000_0000, '0);
        checks++;
        if (o_nacc !== 2 || o_addr[0] !== 32'h2000_0000 || o_addr[1] !== 32'h3000_0000) begin
            failures++;
            $display("FAIL demand_priority nacc=%0d a0=%h a1=%h exp=2/20000000/30000000",
                     o_nacc, o_addr[0], o_addr[1]);
        end
        checks++;
        if (o_dc_data !== mem_val(32'h2000_0000) || o_pref_cnt !== 1 || o_timeout) begin
            failures++;
            $display("FAIL demand_priority_data got=%h pref_cnt=%0d exp=%h/1",
                     o_dc_data, o_pref_cnt, mem_val(32'h2000_0000));
        end
        m_fill(32'h3000_0000);
    endtask

    task automatic test_pref_drop();
        txn(0, 0, 1, '0, 32'h1000_0040, '0);
        checks++;
        if (o_rd_cyc !== 0 || o_pref_cnt !== 1 || o_pref_lat !== 1) begin
            failures++;
            $display("FAIL pref_drop rd_cyc=%0d pref_cnt=%0d lat=%0d exp=0/1/1",
                     o_rd_cyc, o_pref_cnt, o_pref_lat);
        end
    endtask

    task automatic test_write_invalidate();
        logic [LINE_W-1:0] wd;
        wd = rand_line();
        txn(0, 1, 0, 32'h1000_0040, '0, wd);
        checks++;
        if (o_wr_cyc == 0 || o_rd_cyc !== 0 || o_wdata !== wd || o_dc_cnt !== 1) begin
            failures++;
            $display("FAIL write_data wr=%0d rd=%0d got=%h exp=%h",
                     o_wr_cyc, o_rd_cyc, o_wdata, wd);
        end
        mem_store[32'h1000_0040] = wd;
        m_inval(32'h1000_0040);
        txn(1, 0, 0, 32'h1000_0040, '0, '0);
        checks++;
        if (o_nacc !== 1 || o_addr[0] !== 32'h1000_0040 || o_dc_data !== wd) begin
            failures++;
            $display("FAIL write_invalidate nacc=%0d addr=%h data=%h exp=1/10000040/%h",
                     o_nacc, o_addr[0], o_dc_data, wd);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] ln;
        test_reset();
        for (int k = 0; k < 5; k++) begin
            ln = 32'h4000_0000 + 32'(k) * 32'h1000;
            txn(0, 0, 1, '0, ln, '0);
            m_fill(ln);
        end
        txn(1, 0, 0, 32'h4000_0004, '0, '0);
        checks++;
        if (o_nacc !== 1 || o_dc_data !== mem_val(32'h4000_0000)) begin
            failures++;
            $display("FAIL rr_evict nacc=%0d data=%h exp=1/%h",
                     o_nacc, o_dc_data, mem_val(32'h4000_0000));
        end
        txn(1, 0, 0, 32'h4000_1000, '0, '0);
        checks++;
        if (o_nacc !== 0 || o_dc_lat !== 1 || o_dc_data !== mem_val(32'h4000_1000)) begin
            failures++;
            $display("FAIL rr_keep nacc=%0d lat=%0d data=%h exp=0/1/%h",
                     o_nacc, o_dc_lat, o_dc_data, mem_val(32'h4000_1000));
        end
    endtask

    task automatic test_reset_mid_pref();
        bit seen;
        hold_mem = 1'b1;
        @(negedge clk);
        bus.pref_read = 1'b1; bus.pref_addr = 32'h5000_0000;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk); #2;
            if (bus.mem_read) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL midrst_issue mem_read seen=0 exp=1");
        end
        @(negedge clk);
        rst = 1'b1; bus.pref_read = 1'b0;
        @(negedge clk); #2;
        checks++;
        if (bus.mem_read !== 1'b0 || bus.pref_resp !== 1'b0) begin
            failures++;
            $display("FAIL midrst_abort mem_read=%b pref_resp=%b exp=0/0",
                     bus.mem_read, bus.pref_resp);
        end
        rst = 1'b0; hold_mem = 1'b0;
        m_reset();
        txn(1, 0, 0, 32'h4000_1000, '0, '0);
        checks++;
        if (o_nacc !== 1 || o_addr[0] !== 32'h4000_1000) begin
            failures++;
            $display("FAIL midrst_invalid nacc=%0d addr=%h exp=1/40001000", o_nacc, o_addr[0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] da, pa, dl, pl;
        logic [31:0] eq[$];
        logic [LINE_W-1:0] wd, exp_data;
        bit dr, dw, pr, exp_hit;
        int kind;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 3);
            dr = (kind == 1) || (kind == 3 && $urandom_range(0, 1) == 0);
            dw = (kind == 2) || (kind == 3 && !dr);
            pr = (kind == 0) || (kind == 3);
            da = 32'h6000_0000 + 32'($urandom_range(0, 7)) * 32 + 32'($urandom_range(0, 31));
            pa = 32'h6000_0000 + 32'($urandom_range(0, 7)) * 32 + 32'($urandom_range(0, 31));
            dl = line_of(da); pl = line_of(pa);
            wd = rand_line();
            eq.delete(); exp_hit = 0; exp_data = '0;
            if (dw) begin
                m_inval(dl);
                mem_store[dl] = wd;
                eq.push_back(dl);
            end else if (dr) begin
                if (m_find(dl) >= 0) begin
                    exp_hit = 1; exp_data = m_data[m_find(dl)];
                end else begin
                    exp_data = mem_val(dl); eq.push_back(dl);
                end
            end
            if (pr && m_find(pl) < 0) begin
                eq.push_back(pl);
                m_fill(pl);
            end
            txn(dr, dw, pr, da, pa, wd);
            checks++;
            if (o_timeout || o_both || o_unstable || o_leak) begin
                failures++;
                $display("FAIL rnd%0d_protocol timeout=%0d both=%0d unstable=%0d leak=%0d exp=0",
                         n, o_timeout, o_both, o_unstable, o_leak);
            end
            checks++;
            if (o_nacc !== eq.size() ||
                (eq.size() > 0 && o_addr[0] !== eq[0]) ||
                (eq.size() > 1 && o_addr[1] !== eq[1])) begin
                failures++;
                $display("FAIL rnd%0d_mem nacc=%0d a0=%h a1=%h exp_n=%0d",
                         n, o_nacc, o_addr[0], o_addr[1], eq.size());
            end
            checks++;
            if (o_dc_cnt !== ((dr || dw) ? 1 : 0) || o_pref_cnt !== (pr ? 1 : 0)) begin
                failures++;
                $display("FAIL rnd%0d_resp dc_cnt=%0d pref_cnt=%0d exp=%0d/%0d",
                         n, o_dc_cnt, o_pref_cnt, (dr || dw), pr);
            end
            if (dr) begin
                checks++;
                if (o_dc_data !== exp_data || (exp_hit && o_dc_lat !== 1)) begin
                    failures++;
                    $display("FAIL rnd%0d_rdata got=%h lat=%0d exp=%h hit=%0d",
                             n, o_dc_data, o_dc_lat, exp_data, exp_hit);
                end
            end
            if (dw) begin
                checks++;
                if (o_wdata !== wd || o_wr_cyc == 0) begin
                    failures++;
                    $display("FAIL rnd%0d_wdata got=%h exp=%h", n, o_wdata, wd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_pref_fill();
        test_hit_latency();
        test_demand_priority();
        test_pref_drop();
        test_write_invalidate();
        test_round_robin();
        test_reset_mid_pref();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
